// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch / countdown core:
//   - swState_e      : top-level operating state
//   - MOD_DEC/SEXT   : moduli of the BCD decades (decimal and seconds-tens)
//   - NIB_*          : nibble index of each decade inside the packed BCD word
//   - decadeModulus  : modulus of the decade sitting at a given nibble index
// ---------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } swState_e;

    localparam int unsigned MOD_DEC  = 10;
    localparam int unsigned MOD_SEXT = 6;

    localparam int NIB_MS  = 0;
    localparam int NIB_CS  = 1;
    localparam int NIB_DS  = 2;
    localparam int NIB_S   = 3;
    localparam int NIB_10S = 4;
    localparam int NIB_MIN = 5;

    // Every nibble from the minutes upwards is a plain decimal decade; only the
    // tens-of-seconds digit rolls over at 6.
    function automatic int unsigned decadeModulus(input int idx);
        if (idx >= NIB_MIN) begin
            return MOD_DEC;
        end
        case (idx)
            NIB_10S:                       return MOD_SEXT;
            NIB_MS, NIB_CS, NIB_DS, NIB_S: return MOD_DEC;
            default:                       return MOD_DEC;
        endcase
    endfunction

endpackage

// File: rtl/bcd_decade.sv
// ---------------------------------------------------------------------------
// bcd_decade
// One BCD digit of the cascaded time counter.
//   clk_i, rst_ni : clock, asynchronous active-low clear
//   en_i          : count enable (carry/borrow from the lower decade)
//   down_i        : 1 = decrement, 0 = increment
//   load_i        : synchronous load of load_val_i, clamped to MODULUS-1
//   clr_i         : synchronous clear to zero (priority over load and count)
//   load_val_i    : value to load
//   digit_o       : current digit
//   carry_o       : carry (up, at MODULUS-1) or borrow (down, at 0) to the
//                   next decade; combinational so the ripple settles in one cycle
// ---------------------------------------------------------------------------
module bcd_decade
    import stopwatch_pkg::*;
#(
    parameter int unsigned MODULUS = MOD_DEC
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       down_i,
    input  logic       load_i,
    input  logic       clr_i,
    input  logic [3:0] load_val_i,
    output logic [3:0] digit_o,
    output logic       carry_o
);

    localparam logic [3:0] DIGIT_MAX = 4'(MODULUS - 1);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    // Next-digit selection: clear beats load beats counting. Loaded values
    // above the decade maximum are clamped so the counter never holds an
    // illegal BCD code.
    always_comb begin
        digit_d = digit_q;
        carry_o = en_i & (down_i ? (digit_q == 4'd0) : (digit_q == DIGIT_MAX));
        if (clr_i) begin
            digit_d = 4'd0;
        end else if (load_i) begin
            digit_d = (load_val_i > DIGIT_MAX) ? DIGIT_MAX : load_val_i;
        end else if (en_i) begin
            if (down_i) begin
                digit_d = (digit_q == 4'd0) ? DIGIT_MAX : digit_q - 4'd1;
            end else begin
                digit_d = (digit_q == DIGIT_MAX) ? 4'd0 : digit_q + 4'd1;
            end
        end
    end

    // Digit register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;

endmodule

// File: rtl/stopwatch_lap_timer.sv
// ---------------------------------------------------------------------------
// stopwatch_lap_timer
// Stopwatch / countdown core counting 1 kHz ticks in cascaded BCD decades.
//   CLK, RESET_N : system clock, asynchronous active-low reset
//   TICK_1KHZ    : asynchronous 1 kHz square wave; each rising edge is one ms
//   BTN_START    : raw start/pause button (debounced, press = event)
//   BTN_LAP      : raw lap button (debounced, press = event)
//   CLEAR        : clear request level (honoured in IDLE, PAUSE, EXPIRED)
//   DOWN_MODE    : count direction, captured while IDLE
//   LOAD         : load PRELOAD into the counter (IDLE and PAUSE)
//   PRELOAD      : packed BCD preset, LSB nibble = milliseconds
//   DIGITS       : displayed time, lap snapshot when LAP_HELD
//   RUNNING      : state is RUN
//   LAP_HELD     : DIGITS shows a frozen lap snapshot
//   EXPIRED      : countdown reached zero
//   WRAP         : one-cycle pulse when the up-count rolls over to zero
// ---------------------------------------------------------------------------
module stopwatch_lap_timer
    import stopwatch_pkg::*;
#(
    parameter  int MIN_DIGITS     = 2,
    parameter  int DEBOUNCE_TICKS = 20,
    localparam int W              = 4 * (MIN_DIGITS + 5)
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         TICK_1KHZ,
    input  logic         BTN_START,
    input  logic         BTN_LAP,
    input  logic         CLEAR,
    input  logic         DOWN_MODE,
    input  logic         LOAD,
    input  logic [W-1:0] PRELOAD,
    output logic [W-1:0] DIGITS,
    output logic         RUNNING,
    output logic         LAP_HELD,
    output logic         EXPIRED,
    output logic         WRAP
);

    localparam int NUM_DIGITS = MIN_DIGITS + 5;
    localparam int DB_W       = $clog2(DEBOUNCE_TICKS + 1);

    logic tickSync1_q, tickSync2_q, tickSync3_q;
    logic tickStrobe;

    logic [1:0]      btnSync1_q, btnSync2_q, btnCand_q, btnDeb_q, btnDebPrev_q;
    logic [DB_W-1:0] dbCnt_q [2];
    logic            startPress, lapPress;

    swState_e        state_q, state_d;
    logic            lapHeld_q, lapHeld_d;
    logic [W-1:0]    snapshot_q, snapshot_d;
    logic            down_q, down_d;
    logic            wrap_q, wrap_d;
    logic [W-1:0]    digits_q;

    logic              countEn, cntLoad, cntClr;
    logic [NUM_DIGITS:0] carry;
    logic [W-1:0]      count;
    logic              countIsOne;

    // Tick path: two flops to resynchronise the free-running square wave, a
    // third to find its rising edge so each ms produces one CLK-wide strobe.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tickSync1_q <= 1'b0;
            tickSync2_q <= 1'b0;
            tickSync3_q <= 1'b0;
        end else begin
            tickSync1_q <= TICK_1KHZ;
            tickSync2_q <= tickSync1_q;
            tickSync3_q <= tickSync2_q;
        end
    end

    assign tickStrobe = tickSync2_q & ~tickSync3_q;

    // Button debounce, bit 0 = START, bit 1 = LAP. A level must stay unchanged
    // across DEBOUNCE_TICKS tick strobes before it replaces the debounced
    // level; any change of the synchronised level restarts the count.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            btnSync1_q   <= 2'b00;
            btnSync2_q   <= 2'b00;
            btnCand_q    <= 2'b00;
            btnDeb_q     <= 2'b00;
            btnDebPrev_q <= 2'b00;
            dbCnt_q[0]   <= '0;
            dbCnt_q[1]   <= '0;
        end else begin
            btnSync1_q   <= {BTN_LAP, BTN_START};
            btnSync2_q   <= btnSync1_q;
            btnDebPrev_q <= btnDeb_q;
            for (int i = 0; i < 2; i++) begin
                if (btnSync2_q[i] != btnCand_q[i]) begin
                    btnCand_q[i] <= btnSync2_q[i];
                    dbCnt_q[i]   <= '0;
                end else if (tickStrobe && (dbCnt_q[i] != DB_W'(DEBOUNCE_TICKS))) begin
                    dbCnt_q[i] <= dbCnt_q[i] + 1'b1;
                    if (dbCnt_q[i] == DB_W'(DEBOUNCE_TICKS - 1)) begin
                        btnDeb_q[i] <= btnCand_q[i];
                    end
                end
            end
        end
    end

    // Only the debounced press is an event; release is silent.
    assign startPress = btnDeb_q[0] & ~btnDebPrev_q[0];
    assign lapPress   = btnDeb_q[1] & ~btnDebPrev_q[1];

    // A strobe arriving together with a pause request is dropped.
    assign countEn = (state_q == ST_RUN) && tickStrobe && !startPress;

    assign carry[0] = countEn;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_decade
        bcd_decade #(
            .MODULUS(decadeModulus(i))
        ) u_decade (
            .clk_i      (CLK),
            .rst_ni     (RESET_N),
            .en_i       (carry[i]),
            .down_i     (down_q),
            .load_i     (cntLoad),
            .clr_i      (cntClr),
            .load_val_i (PRELOAD[4*i +: 4]),
            .digit_o    (count[4*i +: 4]),
            .carry_o    (carry[i+1])
        );
    end

    assign countIsOne = (count == W'(1));

    // Operating state machine. The ripple-out of the top decade flags either
    // an up-count rollover or a decrement from zero; in down mode a strobe at
    // a count of 0 or 1 lands on zero, so the counter is forced clear and the
    // state moves to EXPIRED on that same edge.
    always_comb begin
        state_d    = state_q;
        lapHeld_d  = lapHeld_q;
        snapshot_d = snapshot_q;
        down_d     = down_q;
        wrap_d     = 1'b0;
        cntLoad    = 1'b0;
        cntClr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                down_d = DOWN_MODE;
                if (CLEAR) begin
                    cntClr    = 1'b1;
                    lapHeld_d = 1'b0;
                end else if (LOAD) begin
                    cntLoad = 1'b1;
                end
                if (startPress) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (startPress) begin
                    state_d = ST_PAUSE;
                end else begin
                    if (lapPress) begin
                        if (lapHeld_q) begin
                            lapHeld_d = 1'b0;
                        end else begin
                            lapHeld_d  = 1'b1;
                            snapshot_d = count;
                        end
                    end
                    if (countEn && down_q && (carry[NUM_DIGITS] || countIsOne)) begin
                        cntClr  = 1'b1;
                        state_d = ST_EXPIRED;
                    end else if (!down_q && carry[NUM_DIGITS]) begin
                        wrap_d = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (startPress) begin
                    state_d = ST_RUN;
                end else if (CLEAR) begin
                    state_d   = ST_IDLE;
                    cntClr    = 1'b1;
                    lapHeld_d = 1'b0;
                end else begin
                    if (LOAD) begin
                        cntLoad = 1'b1;
                    end
                    if (lapPress) begin
                        lapHeld_d = 1'b0;
                    end
                end
            end
            ST_EXPIRED: begin
                if (CLEAR) begin
                    state_d   = ST_IDLE;
                    lapHeld_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, lap and display registers. DIGITS is re-registered from the
    // counter or the snapshot so the display never sees the carry ripple.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            lapHeld_q  <= 1'b0;
            snapshot_q <= '0;
            down_q     <= 1'b0;
            wrap_q     <= 1'b0;
            digits_q   <= '0;
        end else begin
            state_q    <= state_d;
            lapHeld_q  <= lapHeld_d;
            snapshot_q <= snapshot_d;
            down_q     <= down_d;
            wrap_q     <= wrap_d;
            digits_q   <= lapHeld_q ? snapshot_q : count;
        end
    end

    assign DIGITS   = digits_q;
    assign RUNNING  = (state_q == ST_RUN);
    assign LAP_HELD = lapHeld_q;
    assign EXPIRED  = (state_q == ST_EXPIRED);
    assign WRAP     = wrap_q;

endmodule
